riscv_hwloop_regfile: RTL and testbench

Storage and bookkeeping stage directly upstream of the hardware-loop controller. It holds start address, end address and iteration counter for each hardware loop and feeds them to the controller every cycle. It applies the controller's decrement requests and tracks which decrements are still in flight so the controller can resolve the counter value 2 case. It is written by the ID stage on lp.setup / lp.start / lp.end / lp.count instructions.

---
 rtl/riscv_hwloop_regfile.sv | 91 +++++++++
 tb/tb_riscv_hwloop_regfile.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_hwloop_regfile.sv
// Hardware-loop register file: start/end/counter per loop plus decrement-in-flight flags.
// Optional CSR readback port enabled by defining HWLP_CSR_RDATA_EN.
module riscv_hwloop_regfile #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            hwlp_start_data_i,
    input  logic [31:0]            hwlp_end_data_i,
    input  logic [31:0]            hwlp_cnt_data_i,
    input  logic [2:0]             hwlp_we_i,
    input  logic [N_REG_BITS-1:0]  hwlp_regid_i,
    input  logic                   valid_i,
    input  logic [N_REGS-1:0]      hwlp_dec_cnt_i,
    output logic [N_REGS*32-1:0]   hwlp_start_addr_o,
    output logic [N_REGS*32-1:0]   hwlp_end_addr_o,
    output logic [N_REGS*32-1:0]   hwlp_counter_o,
    output logic [N_REGS-1:0]      hwlp_dec_cnt_id_o
`ifdef HWLP_CSR_RDATA_EN
    ,
    input  logic [N_REG_BITS-1:0]  csr_hwlp_regid_i,
    input  logic [1:0]             csr_hwlp_sel_i,
    output logic [31:0]            csr_hwlp_rdata_o
`endif
);

    logic [N_REGS-1:0][31:0] start_q;
    logic [N_REGS-1:0][31:0] end_q;
    logic [N_REGS-1:0][31:0] cnt_q;
    logic [N_REGS-1:0]       pend_q;
    logic [N_REGS-1:0]       wr_hit;
    logic [N_REGS-1:0]       dec_apply;

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

    // An out-of-range index matches no loop, so such writes fall through untouched.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < N_REGS; i++) begin
            wr_hit[i] = (32'(hwlp_regid_i) == i);
        end
        dec_apply = hwlp_dec_cnt_i & {N_REGS{valid_i}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (hwlp_we_i[0] && wr_hit[i]) start_q[i] <= hwlp_start_data_i;
                if (hwlp_we_i[1] && wr_hit[i]) end_q[i]   <= hwlp_end_data_i;
                // A counter write overrides a same-cycle decrement and drops its pending flag.
                if (hwlp_we_i[2] && wr_hit[i]) begin
                    cnt_q[i]  <= hwlp_cnt_data_i;
                    pend_q[i] <= 1'b0;
                end else if (dec_apply[i]) begin
                    cnt_q[i]  <= sat_dec(cnt_q[i]);
                    pend_q[i] <= 1'b1;
                end else begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    assign hwlp_start_addr_o = start_q;
    assign hwlp_end_addr_o   = end_q;
    assign hwlp_counter_o    = cnt_q;
    assign hwlp_dec_cnt_id_o = pend_q;

`ifdef HWLP_CSR_RDATA_EN
    always_comb begin
        csr_hwlp_rdata_o = 32'd0;
        if (32'(csr_hwlp_regid_i) < N_REGS) begin
            case (csr_hwlp_sel_i)
                2'd0:    csr_hwlp_rdata_o = start_q[csr_hwlp_regid_i];
                2'd1:    csr_hwlp_rdata_o = end_q[csr_hwlp_regid_i];
                2'd2:    csr_hwlp_rdata_o = cnt_q[csr_hwlp_regid_i];
                default: csr_hwlp_rdata_o = 32'd0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_riscv_hwloop_regfile.sv
// Self-checking bench for riscv_hwloop_regfile: directed scenarios then random traffic vs a reference model.
module tb_riscv_hwloop_regfile;

    localparam int N_REGS     = 2;
    localparam int N_REG_BITS = 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [31:0]           start_d, end_d, cnt_d;
    logic [2:0]            we;
    logic [N_REG_BITS-1:0] regid;
    logic                  valid;
    logic [N_REGS-1:0]     dec;
    logic [N_REGS*32-1:0]  start_o, end_o, cnt_o;
    logic [N_REGS-1:0]     pend_o;
`ifdef HWLP_CSR_RDATA_EN
    logic [N_REG_BITS-1:0] csr_regid;
    logic [1:0]            csr_sel;
    logic [31:0]           csr_rdata;
`endif

    always #5 clk = ~clk;

    riscv_hwloop_regfile #(.N_REGS(N_REGS), .N_REG_BITS(N_REG_BITS)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hwlp_start_data_i (start_d),
        .hwlp_end_data_i   (end_d),
        .hwlp_cnt_data_i   (cnt_d),
        .hwlp_we_i         (we),
        .hwlp_regid_i      (regid),
        .valid_i           (valid),
        .hwlp_dec_cnt_i    (dec),
        .hwlp_start_addr_o (start_o),
        .hwlp_end_addr_o   (end_o),
        .hwlp_counter_o    (cnt_o),
        .hwlp_dec_cnt_id_o (pend_o)
`ifdef HWLP_CSR_RDATA_EN
        ,
        .csr_hwlp_regid_i  (csr_regid),
        .csr_hwlp_sel_i    (csr_sel),
        .csr_hwlp_rdata_o  (csr_rdata)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    longint m_start [N_REGS];
    longint m_end   [N_REGS];
    longint m_cnt   [N_REGS];
    int     m_pend  [N_REGS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_REGS; i++) begin
            m_start[i] = 0; m_end[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N_REGS; i++) begin
            chk($sformatf("start%0d", i), start_o[i*32 +: 32], 32'(m_start[i]));
            chk($sformatf("end%0d", i),   end_o[i*32 +: 32],   32'(m_end[i]));
            chk($sformatf("cnt%0d", i),   cnt_o[i*32 +: 32],   32'(m_cnt[i]));
            chk($sformatf("pend%0d", i),  32'(pend_o[i]),      32'(m_pend[i]));
        end
`ifdef HWLP_CSR_RDATA_EN
        begin
            longint exp_csr;
            int     r;
            r = int'(csr_regid);
            case (csr_sel)
                2'd0:    exp_csr = m_start[r];
                2'd1:    exp_csr = m_end[r];
                2'd2:    exp_csr = m_cnt[r];
                default: exp_csr = 0;
            endcase
            chk($sformatf("csr sel%0d id%0d", csr_sel, r), csr_rdata, 32'(exp_csr));
        end
`endif
    endtask

    task automatic set_in(input logic [2:0] w, input int id, input logic [31:0] s,
                          input logic [31:0] e, input logic [31:0] c,
                          input logic v, input logic [N_REGS-1:0] d);
        we = w; regid = N_REG_BITS'(id); start_d = s; end_d = e; cnt_d = c;
        valid = v; dec = d;
    endtask

    // Advance one clock: predict next state from the spec rules, then compare just after the edge.
    task automatic cycle();
        for (int i = 0; i < N_REGS; i++) begin
            bit hit;
            bit decr;
            hit  = (int'(regid) == i);
            decr = dec[i] && valid;
            if (hit && we[0]) m_start[i] = start_d;
            if (hit && we[1]) m_end[i]   = end_d;
            if (hit && we[2]) begin
                m_cnt[i]  = cnt_d;
                m_pend[i] = 0;
            end else if (decr) begin
                m_cnt[i]  = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                m_pend[i] = 1;
            end else begin
                m_pend[i] = 0;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        set_in(3'b000, 0, 32'd0, 32'd0, 32'd0, 1'b0, '0);
        cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(3'b000, 0, 32'd0, 32'd0, 32'd0, 1'b0, '0);
`ifdef HWLP_CSR_RDATA_EN
        csr_regid = '0;
        csr_sel   = 2'd0;
`endif
        model_reset();
        #2;
        check_all();
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full write of loop 1, loop 0 untouched
        set_in(3'b111, 1, 32'h100, 32'h120, 32'd3, 1'b0, '0);
        cycle();
        chk("wr1 start", start_o[32 +: 32], 32'h100);
        chk("wr1 cnt",   cnt_o[32 +: 32],   32'd3);
        chk("wr1 cnt0",  cnt_o[31:0],       32'd0);

        // Two back-to-back decrements from 2
        set_in(3'b100, 0, 32'd0, 32'd0, 32'd2, 1'b0, '0);
        cycle();
        set_in(3'b000, 0, 32'd0, 32'd0, 32'd0, 1'b1, 2'b01);
        cycle();
        chk("dec a cnt0",  cnt_o[31:0], 32'd1);
        chk("dec a pend0", 32'(pend_o[0]), 32'd1);
        cycle();
        chk("dec b cnt0",  cnt_o[31:0], 32'd0);
        chk("dec b pend0", 32'(pend_o[0]), 32'd1);
        idle();
        chk("dec c pend0", 32'(pend_o[0]), 32'd0);

        // Saturation at zero still flags pending
        set_in(3'b000, 0, 32'd0, 32'd0, 32'd0, 1'b1, 2'b01);
        cycle();
        chk("sat cnt0",  cnt_o[31:0], 32'd0);
        chk("sat pend0", 32'(pend_o[0]), 32'd1);

        // Decrement request without valid_i does nothing
        set_in(3'b000, 0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b10);
        cycle();
        chk("noval cnt1", cnt_o[32 +: 32], 32'd3);

        // Write/decrement collisions
        set_in(3'b100, 0, 32'd0, 32'd0, 32'd7, 1'b1, 2'b01);
        cycle();
        chk("coll cnt0",  cnt_o[31:0], 32'd7);
        chk("coll pend0", 32'(pend_o[0]), 32'd0);
        set_in(3'b100, 0, 32'd0, 32'd0, 32'd7, 1'b1, 2'b10);
        cycle();
        chk("cross cnt1",  cnt_o[32 +: 32], 32'd2);
        chk("cross pend1", 32'(pend_o[1]), 32'd1);

        // Illegal multi-bit decrement: both loops decrement
        set_in(3'b000, 0, 32'd0, 32'd0, 32'd0, 1'b1, 2'b11);
        cycle();

`ifdef HWLP_CSR_RDATA_EN
        set_in(3'b010, 1, 32'd0, 32'h200, 32'd0, 1'b0, '0);
        csr_regid = 1'b1;
        csr_sel   = 2'd1;
        cycle();
        chk("csr end1", csr_rdata, 32'h200);
        csr_sel = 2'd3;
        #1;
        chk("csr sel3", csr_rdata, 32'd0);
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  w;
            logic [31:0] c;
            int          dsel;
            w    = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            c    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
            dsel = $urandom_range(0, 5);
            set_in(w, $urandom_range(0, N_REGS - 1), $urandom, $urandom, c,
                   1'($urandom_range(0, 1)), (dsel < 4) ? N_REGS'(dsel) : '0);
`ifdef HWLP_CSR_RDATA_EN
            csr_regid = N_REG_BITS'($urandom_range(0, N_REGS - 1));
            csr_sel   = 2'($urandom_range(0, 3));
`endif
            cycle();
        end

        // Reset in the middle of a loop clears everything without a clock edge
        set_in(3'b111, 1, 32'h40, 32'h80, 32'd5, 1'b0, '0);
        cycle();
        set_in(3'b000, 0, 32'd0, 32'd0, 32'd0, 1'b1, 2'b10);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst cnt1", cnt_o[32 +: 32], 32'd0);
        #2 rst_n = 1'b1;
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
